// File: rtl/axi_cdc_src_isolate_ctrl.sv
// Isolation/drain controller for the AXI CDC source half: caps outstanding AW/AR, drains on request.
// Optional build macro AXI_CDC_ISO_TIMEOUT_EN adds DrainTimeout and sticky drain_timeout_o.
package axi_cdc_src_isolate_ctrl_pkg;
   typedef struct packed {
      logic [3:0]  id;
      logic [15:0] addr;
      logic [7:0]  len;
   } ax_chan_t;
   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  strb;
      logic        last;
   } w_chan_t;
   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } b_chan_t;
   typedef struct packed {
      logic [3:0]  id;
      logic [15:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_chan_t;
   typedef struct packed {
      ax_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ax_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;
   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      b_chan_t b;
      logic    b_valid;
      r_chan_t r;
      logic    r_valid;
   } axi_resp_t;
endpackage

module axi_cdc_src_isolate_ctrl #(
   parameter int unsigned MaxTxns = 8,
`ifdef AXI_CDC_ISO_TIMEOUT_EN
   parameter int unsigned DrainTimeout = 1024,
`endif
   parameter type axi_req_t  = axi_cdc_src_isolate_ctrl_pkg::axi_req_t,
   parameter type axi_resp_t = axi_cdc_src_isolate_ctrl_pkg::axi_resp_t
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  axi_req_t  slv_req_i,
   output axi_resp_t slv_resp_o,
   output axi_req_t  mst_req_o,
   input  axi_resp_t mst_resp_i,
   input  logic      isolate_i,
`ifdef AXI_CDC_ISO_TIMEOUT_EN
   output logic      drain_timeout_o,
`endif
   output logic      isolated_o
);

   localparam int unsigned CntW = $clog2(MaxTxns + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(MaxTxns);

   typedef enum logic [1:0] {NORMAL, DRAIN, ISOLATED} state_t;

   state_t state;
   logic [CntW-1:0] wr_cnt, rd_cnt, w_cnt;
   logic aw_open, ar_open, w_open;
   logic aw_hs, ar_hs, w_hs, w_last_hs, b_hs, r_hs, r_last_hs, quiet;

   function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] cnt,
                                                input logic inc, input logic dec);
      if (inc && !dec)
         return cnt + 1'b1;
      else if (dec && !inc && cnt != '0)
         return cnt - 1'b1;
      else
         return cnt;
   endfunction

   assign aw_open   = (state == NORMAL) && (wr_cnt < CntMax);
   assign ar_open   = (state == NORMAL) && (rd_cnt < CntMax);
   assign aw_hs     = slv_req_i.aw_valid && aw_open && mst_resp_i.aw_ready;
   assign ar_hs     = slv_req_i.ar_valid && ar_open && mst_resp_i.ar_ready;
   // W may ride along with its own AW in the same cycle.
   assign w_open    = (w_cnt != '0) || aw_hs;
   assign w_hs      = slv_req_i.w_valid && w_open && mst_resp_i.w_ready;
   assign w_last_hs = w_hs && slv_req_i.w.last;
   assign b_hs      = mst_resp_i.b_valid && slv_req_i.b_ready;
   assign r_hs      = mst_resp_i.r_valid && slv_req_i.r_ready;
   assign r_last_hs = r_hs && mst_resp_i.r.last;
   assign quiet     = (wr_cnt == '0) && (rd_cnt == '0) && (w_cnt == '0) &&
                      !(aw_hs || ar_hs || w_hs || b_hs || r_hs);

   always_comb begin
      mst_req_o           = slv_req_i;
      slv_resp_o          = mst_resp_i;
      mst_req_o.aw_valid  = slv_req_i.aw_valid && aw_open;
      mst_req_o.ar_valid  = slv_req_i.ar_valid && ar_open;
      mst_req_o.w_valid   = slv_req_i.w_valid && w_open;
      slv_resp_o.aw_ready = mst_resp_i.aw_ready && aw_open;
      slv_resp_o.ar_ready = mst_resp_i.ar_ready && ar_open;
      slv_resp_o.w_ready  = mst_resp_i.w_ready && w_open;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
         w_cnt  <= '0;
      end else begin
         wr_cnt <= cnt_next(wr_cnt, aw_hs, b_hs);
         rd_cnt <= cnt_next(rd_cnt, ar_hs, r_last_hs);
         w_cnt  <= cnt_next(w_cnt, aw_hs, w_last_hs);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= NORMAL;
         isolated_o <= 1'b0;
      end else begin
         case (state)
            NORMAL: if (isolate_i) state <= DRAIN;
            DRAIN: begin
               if (!isolate_i) begin
                  state <= NORMAL;
               end else if (quiet) begin
                  state      <= ISOLATED;
                  isolated_o <= 1'b1;
               end
            end
            ISOLATED: begin
               if (!isolate_i) begin
                  state      <= NORMAL;
                  isolated_o <= 1'b0;
               end
            end
            default: begin
               state      <= NORMAL;
               isolated_o <= 1'b0;
            end
         endcase
      end
   end

`ifdef AXI_CDC_ISO_TIMEOUT_EN
   logic [15:0] tmo_cnt;

   // Watchdog only reports; the drain keeps waiting for responses.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tmo_cnt         <= '0;
         drain_timeout_o <= 1'b0;
      end else begin
         if (state == DRAIN) begin
            if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
            if (32'(tmo_cnt) == DrainTimeout - 1) drain_timeout_o <= 1'b1;
         end else begin
            tmo_cnt <= '0;
         end
         if (!isolate_i) drain_timeout_o <= 1'b0;
      end
   end
`endif

   a_wr_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
                                    !(b_hs && !aw_hs && wr_cnt == '0));
   a_rd_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
                                    !(r_last_hs && !ar_hs && rd_cnt == '0));
   a_w_underflow:  assert property (@(posedge clk_i) disable iff (rst_i)
                                    !(w_last_hs && !aw_hs && w_cnt == '0));

endmodule

// File: tb/tb_axi_cdc_src_isolate_ctrl.sv
// Directed bench for axi_cdc_src_isolate_ctrl (MaxTxns=2); timeout case built with AXI_CDC_ISO_TIMEOUT_EN.
module tb_axi_cdc_src_isolate_ctrl;
   import axi_cdc_src_isolate_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst, isolate, isolated;
   axi_req_t  slv_req, mst_req;
   axi_resp_t slv_resp, mst_resp;
`ifdef AXI_CDC_ISO_TIMEOUT_EN
   logic drain_timeout;
`endif
   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   axi_cdc_src_isolate_ctrl #(
      .MaxTxns(2)
`ifdef AXI_CDC_ISO_TIMEOUT_EN
      , .DrainTimeout(16)
`endif
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .slv_req_i(slv_req),
      .slv_resp_o(slv_resp),
      .mst_req_o(mst_req),
      .mst_resp_i(mst_resp),
      .isolate_i(isolate),
`ifdef AXI_CDC_ISO_TIMEOUT_EN
      .drain_timeout_o(drain_timeout),
`endif
      .isolated_o(isolated)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #2;
   endtask

   task automatic do_aw(input logic [7:0] len);
      slv_req.aw_valid = 1'b1;
      slv_req.aw.len = len;
      mst_resp.aw_ready = 1'b1;
      step;
      slv_req.aw_valid = 1'b0;
      mst_resp.aw_ready = 1'b0;
   endtask

   task automatic do_w(input int beats);
      mst_resp.w_ready = 1'b1;
      for (int i = 0; i < beats; i++) begin
         slv_req.w_valid = 1'b1;
         slv_req.w.last = (i == beats - 1);
         step;
      end
      slv_req.w_valid = 1'b0;
      slv_req.w.last = 1'b0;
      mst_resp.w_ready = 1'b0;
   endtask

   task automatic do_b;
      mst_resp.b_valid = 1'b1;
      slv_req.b_ready = 1'b1;
      step;
      mst_resp.b_valid = 1'b0;
      slv_req.b_ready = 1'b0;
   endtask

   task automatic do_ar;
      slv_req.ar_valid = 1'b1;
      mst_resp.ar_ready = 1'b1;
      step;
      slv_req.ar_valid = 1'b0;
      mst_resp.ar_ready = 1'b0;
   endtask

   task automatic do_r;
      mst_resp.r_valid = 1'b1;
      mst_resp.r.last = 1'b1;
      slv_req.r_ready = 1'b1;
      step;
      mst_resp.r_valid = 1'b0;
      mst_resp.r.last = 1'b0;
      slv_req.r_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      slv_req = '0;
      mst_resp = '0;
      isolate = 1'b0;
      rst = 1'b1;
      step;
      step;
      check("rst_isolated", isolated, 0);
      check("rst_wr_cnt", dut.wr_cnt, 0);
      check("rst_rd_cnt", dut.rd_cnt, 0);
      check("rst_w_cnt", dut.w_cnt, 0);
      rst = 1'b0;
      step;

      // Pass-through: four writes (len 3) and four reads.
      for (int i = 0; i < 4; i++) begin
         slv_req.aw_valid = 1'b1;
         slv_req.aw.addr = 16'(16'h100 * (i + 1));
         slv_req.aw.len = 8'd3;
         mst_resp.aw_ready = 1'b1;
         settle;
         check("pt_mst_aw_valid", mst_req.aw_valid, 1);
         check("pt_slv_aw_ready", slv_resp.aw_ready, 1);
         check("pt_aw_addr", mst_req.aw.addr, 32'h100 * (i + 1));
         step;
         slv_req.aw_valid = 1'b0;
         mst_resp.aw_ready = 1'b0;
         check("pt_wr_cnt_one", dut.wr_cnt, 1);
         do_w(4);
         check("pt_w_cnt_zero", dut.w_cnt, 0);
         mst_resp.b_valid = 1'b1;
         mst_resp.b.id = 4'(i);
         slv_req.b_ready = 1'b1;
         settle;
         check("pt_b_valid", slv_resp.b_valid, 1);
         check("pt_b_id", slv_resp.b.id, i);
         step;
         mst_resp.b_valid = 1'b0;
         slv_req.b_ready = 1'b0;
         check("pt_wr_cnt_zero", dut.wr_cnt, 0);
         do_ar;
         check("pt_rd_cnt_one", dut.rd_cnt, 1);
         mst_resp.r.data = 16'(16'hA0 + i);
         do_r;
         check("pt_r_data", slv_resp.r.data, 32'hA0 + i);
         check("pt_rd_cnt_zero", dut.rd_cnt, 0);
         check("pt_isolated", isolated, 0);
      end

      // Outstanding-write limit with B held off.
      slv_req.aw_valid = 1'b1;
      slv_req.aw.len = 8'd0;
      mst_resp.aw_ready = 1'b1;
      step;
      step;
      settle;
      check("lim_wr_cnt_two", dut.wr_cnt, 2);
      check("lim_slv_aw_ready", slv_resp.aw_ready, 0);
      check("lim_mst_aw_valid", mst_req.aw_valid, 0);
      do_w(1);
      do_w(1);
      settle;
      check("lim_still_blocked", slv_resp.aw_ready, 0);
      mst_resp.b_valid = 1'b1;
      slv_req.b_ready = 1'b1;
      settle;
      check("lim_blocked_at_b", slv_resp.aw_ready, 0);
      step;
      mst_resp.b_valid = 1'b0;
      slv_req.b_ready = 1'b0;
      settle;
      check("lim_open_after_b", slv_resp.aw_ready, 1);
      step;
      slv_req.aw_valid = 1'b0;
      mst_resp.aw_ready = 1'b0;
      check("lim_wr_cnt_after", dut.wr_cnt, 2);
      check("lim_w_cnt_after", dut.w_cnt, 1);
      do_w(1);
      do_b;
      do_b;
      check("lim_wr_cnt_end", dut.wr_cnt, 0);

      // Drain: two writes and one read outstanding.
      do_aw(8'd3);
      do_w(4);
      do_aw(8'd3);
      do_w(4);
      do_ar;
      isolate = 1'b1;
      step;
      slv_req.ar_valid = 1'b1;
      mst_resp.ar_ready = 1'b1;
      settle;
      check("drn_slv_ar_ready", slv_resp.ar_ready, 0);
      check("drn_mst_ar_valid", mst_req.ar_valid, 0);
      check("drn_iso_early", isolated, 0);
      do_b;
      do_b;
      check("drn_iso_wr_done", isolated, 0);
      do_r;
      check("drn_rd_cnt_zero", dut.rd_cnt, 0);
      check("drn_iso_at_zero", isolated, 0);
      step;
      check("drn_iso_set", isolated, 1);
      check("drn_ar_still_blocked", slv_resp.ar_ready, 0);
      isolate = 1'b0;
      step;
      check("drn_iso_clear", isolated, 0);
      settle;
      check("drn_ar_reopen", slv_resp.ar_ready, 1);
      step;
      slv_req.ar_valid = 1'b0;
      mst_resp.ar_ready = 1'b0;
      check("drn_rd_cnt_after", dut.rd_cnt, 1);
      do_r;

      // Abort: AW accepted the cycle isolate rises, next AW blocked until abort.
      slv_req.aw_valid = 1'b1;
      slv_req.aw.len = 8'd3;
      mst_resp.aw_ready = 1'b1;
      isolate = 1'b1;
      settle;
      check("abt_same_cycle_aw", slv_resp.aw_ready, 1);
      step;
      check("abt_wr_cnt_one", dut.wr_cnt, 1);
      settle;
      check("abt_aw_blocked", slv_resp.aw_ready, 0);
      step;
      check("abt_iso_a", isolated, 0);
      step;
      isolate = 1'b0;
      check("abt_iso_b", isolated, 0);
      step;
      check("abt_iso_c", isolated, 0);
      settle;
      check("abt_aw_reopen", slv_resp.aw_ready, 1);
      step;
      slv_req.aw_valid = 1'b0;
      mst_resp.aw_ready = 1'b0;
      check("abt_wr_cnt_two", dut.wr_cnt, 2);
      do_w(4);
      do_w(4);
      do_b;
      do_b;
      check("abt_wr_cnt_end", dut.wr_cnt, 0);

      // W arriving before its AW.
      slv_req.w_valid = 1'b1;
      slv_req.w.last = 1'b0;
      mst_resp.w_ready = 1'b1;
      settle;
      check("wba_w_ready_a", slv_resp.w_ready, 0);
      check("wba_w_valid_a", mst_req.w_valid, 0);
      step;
      settle;
      check("wba_w_ready_b", slv_resp.w_ready, 0);
      step;
      slv_req.aw_valid = 1'b1;
      slv_req.aw.len = 8'd3;
      mst_resp.aw_ready = 1'b1;
      settle;
      check("wba_w_ready_c", slv_resp.w_ready, 1);
      check("wba_w_valid_c", mst_req.w_valid, 1);
      check("wba_aw_ready_c", slv_resp.aw_ready, 1);
      step;
      slv_req.aw_valid = 1'b0;
      mst_resp.aw_ready = 1'b0;
      check("wba_w_cnt_one", dut.w_cnt, 1);
      for (int i = 1; i < 4; i++) begin
         slv_req.w.last = (i == 3);
         step;
      end
      slv_req.w_valid = 1'b0;
      slv_req.w.last = 1'b0;
      mst_resp.w_ready = 1'b0;
      check("wba_w_cnt_zero", dut.w_cnt, 0);
      do_b;

`ifdef AXI_CDC_ISO_TIMEOUT_EN
      do_aw(8'd0);
      do_w(1);
      isolate = 1'b1;
      step;
      for (int k = 0; k < 15; k++) begin
         check("tmo_low", drain_timeout, 0);
         step;
      end
      check("tmo_low_last", drain_timeout, 0);
      step;
      check("tmo_set", drain_timeout, 1);
      step;
      step;
      check("tmo_sticky", drain_timeout, 1);
      check("tmo_not_isolated", isolated, 0);
      isolate = 1'b0;
      step;
      check("tmo_clear", drain_timeout, 0);
      do_b;
`endif

      // Reset mid-burst while draining.
      do_aw(8'd3);
      isolate = 1'b1;
      step;
      rst = 1'b1;
      step;
      rst = 1'b0;
      isolate = 1'b0;
      check("rmb_wr_cnt", dut.wr_cnt, 0);
      check("rmb_w_cnt", dut.w_cnt, 0);
      check("rmb_isolated", isolated, 0);
      slv_req.aw_valid = 1'b1;
      mst_resp.aw_ready = 1'b1;
      settle;
      check("rmb_aw_open", slv_resp.aw_ready, 1);
      slv_req.aw_valid = 1'b0;
      mst_resp.aw_ready = 1'b0;
      step;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
